// File: rtl/bcd_alu_pkg.sv
// Shared types and frame constants for the serial BCD ALU frame controller.
// Operand and result widths follow from the BCD digit count.
package bcd_alu_pkg;

    localparam int BCD_DIGITS = 4;
    localparam int OPND_W     = 4 * BCD_DIGITS;
    localparam int RES_W      = 4 * (BCD_DIGITS + 1);
    localparam int FRAME_W    = 2 * OPND_W + 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RECV = 3'd1,
        S_CALC = 3'd2,
        S_LOAD = 3'd3,
        S_SEND = 3'd4,
        S_DONE = 3'd5
    } state_e;

endpackage

// File: rtl/seq_bit_counter.sv
// Up-counter with synchronous clear and increment.
// o_term flags that the next increment reaches i_limit.
module seq_bit_counter #(
    parameter int CNT_W = 6
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_inc,
    input  logic [CNT_W-1:0] i_limit,
    output logic             o_term
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign o_term    = (w_cnt_inc == i_limit);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_inc)
            r_cnt <= w_cnt_inc;
    end

endmodule

// File: rtl/bcd_alu_seq.sv
// Frame controller for the serial BCD ALU: counts the input frame, waits out
// the ALU settle time, loads the PISO and strobes the result out bit by bit.
module bcd_alu_seq
    import bcd_alu_pkg::*;
#(
    parameter int IN_BITS  = FRAME_W,
    parameter int OUT_BITS = RES_W,
    parameter int ALU_LAT  = 1,
    parameter int CNT_W    = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sipo_sh,
    output logic piso_ld,
    output logic piso_sh,
    output logic out_valid,
    output logic busy,
    output logic done,
    output logic frame_err
);

    localparam logic [CNT_W-1:0] LIM_IN  = CNT_W'(IN_BITS);
    localparam logic [CNT_W-1:0] LIM_LAT = CNT_W'(ALU_LAT);
    localparam logic [CNT_W-1:0] LIM_OUT = CNT_W'(OUT_BITS);

    state_e           r_state;
    state_e           w_state_nxt;
    logic             r_armed;
    logic             w_arm_set;
    logic             w_arm_clr;
    logic             w_cnt_clr;
    logic             w_cnt_inc;
    logic             w_cnt_term;
    logic [CNT_W-1:0] w_limit;

    seq_bit_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_clr   (w_cnt_clr),
        .i_inc   (w_cnt_inc),
        .i_limit (w_limit),
        .o_term  (w_cnt_term)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_armed <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            if (w_arm_clr)
                r_armed <= 1'b0;
            else if (w_arm_set)
                r_armed <= 1'b1;
        end
    end

    // The IDLE shift is gated by rst so nothing leaks out while reset is held.
    always_comb begin
        w_state_nxt = r_state;
        w_arm_set   = 1'b0;
        w_arm_clr   = 1'b0;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
        w_limit     = LIM_IN;
        sipo_sh     = 1'b0;
        piso_ld     = 1'b0;
        piso_sh     = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        frame_err   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (en && r_armed && rst) begin
                    sipo_sh     = 1'b1;
                    w_cnt_inc   = 1'b1;
                    w_arm_clr   = 1'b1;
                    w_state_nxt = S_RECV;
                end else begin
                    w_cnt_clr = 1'b1;
                    w_arm_set = !en;
                end
            end
            S_RECV: begin
                busy    = 1'b1;
                sipo_sh = en;
                if (!en) begin
                    frame_err   = 1'b1;
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_cnt_term) begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = S_CALC;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            S_CALC: begin
                busy    = 1'b1;
                w_limit = LIM_LAT;
                if (w_cnt_term) begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = S_LOAD;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            S_LOAD: begin
                busy        = 1'b1;
                piso_ld     = 1'b1;
                w_cnt_clr   = 1'b1;
                w_state_nxt = S_SEND;
            end
            S_SEND: begin
                busy      = 1'b1;
                piso_sh   = 1'b1;
                out_valid = 1'b1;
                w_limit   = LIM_OUT;
                if (w_cnt_term) begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            S_DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_cnt_clr   = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_cnt_clr   = 1'b1;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // The three datapath enables are mutually exclusive.
    assert property (@(posedge clk) disable iff (!rst)
        $onehot0({sipo_sh, piso_ld, piso_sh}));

endmodule

// File: tb/tb_bcd_alu_seq.sv
// Scoreboard bench for bcd_alu_seq: two builds (ALU_LAT 1 and 3) share stimulus,
// a small SIPO/ALU/PISO model rides on the first build to check the result bits.
module tb_bcd_alu_seq;

    localparam logic [6:0] V_SIPO  = 7'b1000000;
    localparam logic [6:0] V_LD    = 7'b0100000;
    localparam logic [6:0] V_SH    = 7'b0010000;
    localparam logic [6:0] V_VALID = 7'b0001000;
    localparam logic [6:0] V_BUSY  = 7'b0000100;
    localparam logic [6:0] V_DONE  = 7'b0000010;
    localparam logic [6:0] V_ERR   = 7'b0000001;

    typedef struct {
        int         cyc;
        logic [6:0] vec;
    } exp_t;

    logic clk = 1'b0;
    logic rstN;
    logic en;
    logic din;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q0[$];
    exp_t q1[$];

    logic sipoSh0, pisoLd0, pisoSh0, outValid0, busy0, done0, frameErr0;
    logic sipoSh1, pisoLd1, pisoSh1, outValid1, busy1, done1, frameErr1;
    logic [6:0] vec0;
    logic [6:0] vec1;
    logic [32:0] sipoReg = '0;
    logic [19:0] pisoReg = '0;
    logic [19:0] resBits = '0;

    assign vec0 = {sipoSh0, pisoLd0, pisoSh0, outValid0, busy0, done0, frameErr0};
    assign vec1 = {sipoSh1, pisoLd1, pisoSh1, outValid1, busy1, done1, frameErr1};

    bcd_alu_seq #(.ALU_LAT(1)) dut0 (
        .clk(clk), .rst(rstN), .en(en),
        .sipo_sh(sipoSh0), .piso_ld(pisoLd0), .piso_sh(pisoSh0),
        .out_valid(outValid0), .busy(busy0), .done(done0), .frame_err(frameErr0)
    );

    bcd_alu_seq #(.ALU_LAT(3)) dut1 (
        .clk(clk), .rst(rstN), .en(en),
        .sipo_sh(sipoSh1), .piso_ld(pisoLd1), .piso_sh(pisoSh1),
        .out_valid(outValid1), .busy(busy1), .done(done1), .frame_err(frameErr1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [19:0] bcdAlu(input logic [32:0] f);
        int a = 0;
        int b = 0;
        int r;
        logic [19:0] res;
        for (int i = 3; i >= 0; i--) begin
            a = a * 10 + int'(f[17 + 4 * i +: 4]);
            b = b * 10 + int'(f[1 + 4 * i +: 4]);
        end
        r = f[0] ? a - b : a + b;
        for (int i = 0; i < 5; i++) begin
            res[4 * i +: 4] = 4'(r % 10);
            r = r / 10;
        end
        return res;
    endfunction

    // Datapath model driven only by the controller enables of the ALU_LAT=1 build.
    always @(posedge clk) begin
        if (sipoSh0)
            sipoReg <= {sipoReg[31:0], din};
        if (pisoLd0)
            pisoReg <= bcdAlu(sipoReg);
        else if (pisoSh0)
            pisoReg <= {pisoReg[18:0], 1'b0};
    end

    always @(negedge clk) begin
        if (outValid0)
            resBits <= {resBits[18:0], pisoReg[19]};
    end

    // Expected output pattern for frame-relative cycle k.
    function automatic logic [6:0] expVec(input int k, input int lat, input int high);
        if (high < 33) begin
            if (k < high)  return V_SIPO | ((k > 0) ? V_BUSY : 7'b0);
            if (k == high) return V_ERR | V_BUSY;
            return 7'b0;
        end
        if (k <= 32)           return V_SIPO | ((k > 0) ? V_BUSY : 7'b0);
        if (k <= 32 + lat)     return V_BUSY;
        if (k == 33 + lat)     return V_LD | V_BUSY;
        if (k <= 53 + lat)     return V_SH | V_VALID | V_BUSY;
        if (k == 54 + lat)     return V_DONE | V_BUSY;
        return 7'b0;
    endfunction

    task automatic pushFrame(input int which, input int c0, input int lat,
                             input int high, input int rstAt, input int total);
        exp_t e;
        int lim;
        lim = (rstAt < 0) ? total : rstAt;
        for (int k = 0; k < lim; k++) begin
            e.cyc = c0 + k;
            e.vec = expVec(k, lat, high);
            if (e.vec != 7'b0) begin
                if (which == 0) q0.push_back(e);
                else            q1.push_back(e);
            end
        end
    endtask

    task automatic checkOutput(input string name, input int actCyc, input logic [6:0] actVec,
                               input int expCyc, input logic [6:0] expVec);
        checks++;
        if (actCyc != expCyc || actVec != expVec) begin
            errors++;
            $display("[TB] FAIL %s: got cycle %0d outputs %b, expected cycle %0d outputs %b",
                     name, actCyc, actVec, expCyc, expVec);
        end
    endtask

    task automatic checkValue(input string name, input logic [19:0] act, input logic [19:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (vec0 != 7'b0) begin
            if (q0.size() == 0) begin
                checkOutput("dut0 unexpected", cyc, vec0, -1, 7'b0);
            end else begin
                e = q0.pop_front();
                checkOutput("dut0 output", cyc, vec0, e.cyc, e.vec);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (vec1 != 7'b0) begin
            if (q1.size() == 0) begin
                checkOutput("dut1 unexpected", cyc, vec1, -1, 7'b0);
            end else begin
                e = q1.pop_front();
                checkOutput("dut1 output", cyc, vec1, e.cyc, e.vec);
            end
        end
    end

    task automatic waitCycle();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input int highCycles, input int pulseAt, input int rstAt,
                                 input logic [32:0] frame, input int total);
        int c0;
        waitCycle();
        c0 = cyc;
        pushFrame(0, c0, 1, highCycles, rstAt, total);
        pushFrame(1, c0, 3, highCycles, rstAt, total);
        for (int k = 0; k < total; k++) begin
            if (k > 0) waitCycle();
            en  = (k < highCycles) || (k == pulseAt);
            din = (k < 33) ? frame[32 - k] : 1'b0;
            if (k == rstAt) begin
                rstN = 1'b0;
                #1;
                checkValue("midReset dut0", {13'b0, vec0}, 20'b0);
                checkValue("midReset dut1", {13'b0, vec1}, 20'b0);
            end
            if (k == rstAt + 2) rstN = 1'b1;
        end
        en  = 1'b0;
        din = 1'b0;
    endtask

    initial begin
        rstN = 1'b0;
        en   = 1'b1;
        din  = 1'b0;
        repeat (3) waitCycle();
        checkValue("reset dut0", {13'b0, vec0}, 20'b0);
        checkValue("reset dut1", {13'b0, vec1}, 20'b0);
        en   = 1'b0;
        rstN = 1'b1;
        repeat (2) waitCycle();

        $display("[TB] full frame, A=1234 B=5678 add");
        applyStimulus(33, -1, -1, {16'h1234, 16'h5678, 1'b0}, 60);
        checkValue("aluResult", resBits, 20'h06912);

        $display("[TB] short frame");
        applyStimulus(10, -1, -1, 33'h0, 15);

        $display("[TB] en stuck high");
        applyStimulus(80, -1, -1, 33'h0, 85);

        $display("[TB] en pulse during SEND");
        applyStimulus(33, 40, -1, 33'h0, 62);

        $display("[TB] reset mid-SEND");
        applyStimulus(33, -1, 45, 33'h0, 52);

        $display("[TB] full frame after reset");
        applyStimulus(33, -1, -1, 33'h0, 62);

        repeat (3) waitCycle();
        checkValue("q0 drained", 20'(q0.size()), 20'd0);
        checkValue("q1 drained", 20'(q1.size()), 20'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
